// File: rtl/led_matrix_pkg.sv
// Shared constants, scan state encoding and sizing helper for the LED row scanner.
package led_matrix_pkg;

   localparam int unsigned N_ROWS     = 8;
   localparam int unsigned ROW_ADDR_W = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DRIVE,
      S_BLANK,
      S_UPDATE
   } scan_state_t;

   // Dwell counter width large enough to hold the longer of the two dwell counts.
   function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned blank);
      return $clog2(((hold > blank) ? hold : blank) + 1);
   endfunction

endpackage

// File: rtl/led_row_scan_ctrl_if.sv
// Framebuffer read port, writer handshake and LED drive bundle of the row scanner.
interface led_row_scan_ctrl_if;
   import led_matrix_pkg::*;

   logic                  ena;
   logic [N_ROWS-1:0]     row_data;
   logic                  upd_req;
   logic [ROW_ADDR_W-1:0] row_addr;
   logic [N_ROWS-1:0]     rows;
   logic [N_ROWS-1:0]     cols;
   logic                  upd_gnt;
   logic                  frame_done;

   // Scanner side.
   modport slave (
      input  ena, row_data, upd_req,
      output row_addr, rows, cols, upd_gnt, frame_done
   );

   // Framebuffer / writer / control side.
   modport master (
      output ena, row_data, upd_req,
      input  row_addr, rows, cols, upd_gnt, frame_done
   );

endinterface

// File: rtl/decoder_3_to_8.sv
// One-hot row decoder with enable; all-zero when disabled.
module decoder_3_to_8
   import led_matrix_pkg::*;
(
   input  logic                  ena,
   input  logic [ROW_ADDR_W-1:0] in,
   output logic [N_ROWS-1:0]     out
);

   // Decode the row address to a single active row line.
   always_comb begin
      out = '0;
      if (ena) out = N_ROWS'(1) << in;
   end

endmodule

// File: rtl/led_row_scan_ctrl.sv
// Time-multiplexed 8-row LED scanner with frame-boundary framebuffer handoff.
module led_row_scan_ctrl
   import led_matrix_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES  = 1000,
   parameter int unsigned BLANK_CYCLES = 16,
   parameter int unsigned CNT_W        = cnt_width(HOLD_CYCLES, BLANK_CYCLES)
) (
   input  logic                clk,
   input  logic                rst_n,
   led_row_scan_ctrl_if.slave  bus
);

   scan_state_t           state_q, state_d;
   logic [ROW_ADDR_W-1:0] row_addr_q, row_addr_d;
   logic [N_ROWS-1:0]     cols_q, cols_d;
   logic                  upd_gnt_q, upd_gnt_d;
   logic                  frame_done_q, frame_done_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  hold_end_c, blank_end_c, last_row_c, drive_c;
   logic [N_ROWS-1:0]     rows_c;

   assign hold_end_c  = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
   assign blank_end_c = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
   assign last_row_c  = (row_addr_q == ROW_ADDR_W'(N_ROWS - 1));
   assign drive_c     = (state_q == S_DRIVE);

   // Next-state, dwell counter and registered output logic.
   always_comb begin
      state_d      = state_q;
      row_addr_d   = row_addr_q;
      cols_d       = cols_q;
      upd_gnt_d    = 1'b0;
      frame_done_d = 1'b0;
      cnt_d        = cnt_q + CNT_W'(1);

      case (state_q)
         S_IDLE: begin
            if (bus.upd_req) begin
               state_d   = S_UPDATE;
               upd_gnt_d = 1'b1;
            end else if (bus.ena) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (!bus.ena) begin
               state_d    = S_IDLE;
               row_addr_d = '0;
               cols_d     = '0;
            end else begin
               cols_d  = bus.row_data;
               state_d = S_DRIVE;
            end
         end
         S_DRIVE: begin
            if (!bus.ena) begin
               state_d    = S_IDLE;
               row_addr_d = '0;
               cols_d     = '0;
            end else if (hold_end_c) begin
               state_d = S_BLANK;
            end
         end
         S_BLANK: begin
            // Frame boundary takes precedence so a finished frame is always reported.
            if (blank_end_c && last_row_c) begin
               frame_done_d = 1'b1;
               row_addr_d   = '0;
               if (bus.upd_req) begin
                  state_d   = S_UPDATE;
                  upd_gnt_d = 1'b1;
               end else if (bus.ena) begin
                  state_d = S_LOAD;
               end else begin
                  state_d = S_IDLE;
                  cols_d  = '0;
               end
            end else if (!bus.ena) begin
               state_d    = S_IDLE;
               row_addr_d = '0;
               cols_d     = '0;
            end else if (blank_end_c) begin
               row_addr_d = row_addr_q + ROW_ADDR_W'(1);
               state_d    = S_LOAD;
            end
         end
         S_UPDATE: begin
            upd_gnt_d = 1'b1;
            if (!bus.upd_req) begin
               upd_gnt_d = 1'b0;
               if (bus.ena) begin
                  state_d = S_LOAD;
               end else begin
                  state_d = S_IDLE;
                  cols_d  = '0;
               end
            end
         end
         default: begin
            state_d    = S_IDLE;
            row_addr_d = '0;
            cols_d     = '0;
         end
      endcase

      // Dwell count restarts on every state entry and is parked outside timed states.
      if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_UPDATE)) cnt_d = '0;
   end

   // State and output registers; reset darkens the matrix immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         row_addr_q   <= '0;
         cols_q       <= '0;
         upd_gnt_q    <= 1'b0;
         frame_done_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         row_addr_q   <= row_addr_d;
         cols_q       <= cols_d;
         upd_gnt_q    <= upd_gnt_d;
         frame_done_q <= frame_done_d;
         cnt_q        <= cnt_d;
      end
   end

   // Row drive decoded from registers only, active in DRIVE.
   decoder_3_to_8 u_row_dec (
      .ena (drive_c),
      .in  (row_addr_q),
      .out (rows_c)
   );

   assign bus.row_addr   = row_addr_q;
   assign bus.rows       = rows_c;
   assign bus.cols       = cols_q;
   assign bus.upd_gnt    = upd_gnt_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_led_row_scan_ctrl.sv
// Randomized scoreboard bench for led_row_scan_ctrl with a frame-position reference model.
module tb_led_row_scan_ctrl;

   localparam int HOLD  = 3;
   localparam int BLANK = 2;
   localparam int P     = 1 + HOLD + BLANK;
   localparam int FRAME = 8 * P;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] fb [8];

   int n_checks = 0;
   int n_errors = 0;

   logic [20:0] exp_q [$];

   led_row_scan_ctrl_if bus ();

   led_row_scan_ctrl #(
      .HOLD_CYCLES  (HOLD),
      .BLANK_CYCLES (BLANK)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Framebuffer combinational read port.
   always_comb bus.row_data = fb[bus.row_addr];

   // Reference model: mode 0 idle, 1 scanning at frame position pos, 2 writer granted.
   int         m_mode = 0;
   int         m_pos  = 0;
   logic [7:0] m_cols = 8'h00;
   logic       m_fd   = 1'b0;

   always @(posedge clk) begin
      int         row, sub;
      logic [7:0] rows_e;
      if (!rst_n) begin
         m_mode = 0;
         m_pos  = 0;
         m_cols = 8'h00;
         m_fd   = 1'b0;
      end else begin
         m_fd = 1'b0;
         case (m_mode)
            0: begin
               if (bus.upd_req) m_mode = 2;
               else if (bus.ena) begin m_mode = 1; m_pos = 0; end
            end
            1: begin
               if (m_pos == FRAME - 1) begin
                  m_fd = 1'b1;
                  if (bus.upd_req) m_mode = 2;
                  else if (bus.ena) m_pos = 0;
                  else begin m_mode = 0; m_cols = 8'h00; end
               end else if (!bus.ena) begin
                  m_mode = 0;
                  m_cols = 8'h00;
               end else begin
                  if (m_pos % P == 0) m_cols = fb[m_pos / P];
                  m_pos++;
               end
            end
            default: begin
               if (!bus.upd_req) begin
                  if (bus.ena) begin m_mode = 1; m_pos = 0; end
                  else begin m_mode = 0; m_cols = 8'h00; end
               end
            end
         endcase
      end
      row    = (m_mode == 1) ? m_pos / P : 0;
      sub    = m_pos % P;
      rows_e = 8'h00;
      if (m_mode == 1 && sub >= 1 && sub <= HOLD) rows_e = 8'(1) << row;
      exp_q.push_back({3'(row), rows_e, m_cols, (m_mode == 2), m_fd});
   end

   // Monitor: compare every presented cycle of DUT outputs against the model.
   always @(negedge clk) begin
      logic [20:0] e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {bus.row_addr, bus.rows, bus.cols, bus.upd_gnt, bus.frame_done};
         n_checks++;
         if (a !== e) begin
            n_errors++;
            $display("FAIL outputs @%0t: got addr=%0d rows=%h cols=%h gnt=%b fd=%b, want addr=%0d rows=%h cols=%h gnt=%b fd=%b",
                     $time, a[20:18], a[17:10], a[9:2], a[1], a[0],
                     e[20:18], e[17:10], e[9:2], e[1], e[0]);
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic wait_rows(input logic [7:0] v, input string tag);
      bit hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         if (bus.rows === v) hit = 1'b1;
      end
      n_checks++;
      if (!hit) begin
         n_errors++;
         $display("FAIL %s: rows never reached %h (last %h)", tag, v, bus.rows);
      end
   endtask

   task automatic wait_gnt(input string tag);
      bit hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         if (bus.upd_gnt === 1'b1) hit = 1'b1;
      end
      n_checks++;
      if (!hit) begin
         n_errors++;
         $display("FAIL %s: upd_gnt never asserted", tag);
      end
   endtask

   initial begin
      int gcnt;
      bus.ena     = 1'b0;
      bus.upd_req = 1'b0;
      for (int r = 0; r < 8; r++) fb[r] = 8'(8'h11 * r);

      // Reset held over several clocks.
      cycles(3);
      rst_n = 1'b1;

      // Continuous scan over two full frames.
      bus.ena = 1'b1;
      cycles(2 * FRAME + 5);

      // Writer request mid-frame waits for the frame boundary.
      wait_rows(8'h08, "row3_drive");
      bus.upd_req = 1'b1;
      wait_gnt("frame_end_grant");
      check("rows_dark_in_grant", 32'(bus.rows), 32'h0);
      cycles(2);
      for (int r = 0; r < 8; r++) fb[r] = 8'($urandom);
      bus.upd_req = 1'b0;
      cycles(20);

      // Scan disable mid-frame.
      wait_rows(8'h20, "row5_drive");
      bus.ena = 1'b0;
      cycles(5);
      bus.ena = 1'b1;

      // Asynchronous reset during row 2 drive.
      wait_rows(8'h04, "row2_drive");
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_rows", 32'(bus.rows), 32'h0);
      check("async_rst_addr", 32'(bus.row_addr), 32'h0);
      check("async_rst_cols", 32'(bus.cols), 32'h0);
      cycles(2);
      rst_n = 1'b1;
      cycles(12);

      // Grant straight from idle.
      bus.ena = 1'b0;
      cycles(4);
      bus.upd_req = 1'b1;
      cycles(4);
      bus.upd_req = 1'b0;
      cycles(4);

      // Randomized traffic with a protocol-abiding writer.
      bus.ena = 1'b1;
      gcnt    = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (bus.upd_gnt) fb[$urandom_range(0, 7)] = 8'($urandom);
         if (!bus.upd_req) begin
            gcnt = 0;
            if ($urandom_range(0, 29) == 0) bus.upd_req = 1'b1;
         end else begin
            if (bus.upd_gnt) gcnt++;
            if (gcnt >= 2 && $urandom_range(0, 2) == 0) bus.upd_req = 1'b0;
         end
         if ($urandom_range(0, 59) == 0) bus.ena = ~bus.ena;
      end

      bus.ena     = 1'b0;
      bus.upd_req = 1'b0;
      cycles(6);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
